st7066u_bus_driver: RTL and testbench
=====================================

# st7066u_bus_driver

Physical-bus stage for the ST7066U character LCD, directly downstream of the clock-display sequencer. It takes the sequencer's compact transaction request (RS flag, 3-bit selector, 4-bit value, enable trigger) and expands it into a full 8-bit command or ASCII byte. It then drives RS/RW/E/DB[7:0] with the required setup, pulse-width and hold timing. One transaction is in flight at a time; a busy flag and a sticky overrun flag report flow-control status.

## Interface
- SETUP_CYC, 1: cycles from RS/DB valid to E rising (1..255).
- PULSE_CYC, 1: cycles E is held high (1..255).
- HOLD_CYC, 1: cycles RS/DB are held after E falls (1..255).
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_e_trigger  in  1  transaction request; a rising edge starts one transaction.
- i_data  in  1  0 = command byte (RS=0), 1 = character byte (RS=1).
- i_sel  in  3  byte selector; see Operation.
- i_val  in  4  value field; see Operation.
- o_lcd_rs  out  1  LCD register select.
- o_lcd_rw  out  1  LCD read/write; constant 0 (write only).
- o_lcd_e  out  1  LCD enable strobe.
- o_lcd_db  out  8  LCD data bus.
- o_busy  out  1  high while a transaction is in progress.
- o_overrun  out  1  sticky; set when a request edge arrives while busy.

## Operation
- Edge detect: register trig_d <= i_e_trigger. The request condition is i_e_trigger & ~trig_d.
  - trig_d resets to 0, so a trigger already high on the first cycle after reset counts as a request. This captures the sequencer's first init command.
- Request decode, command mode (i_data=0):
  - sel 100 -> 0x38, function set (8-bit, 2 lines).
  - sel 101 -> 0x0C, display on.
  - sel 110 -> 0x01, clear.
  - sel 111 -> 0x06, entry mode.
  - sel 000 -> 0x80 | {4'b0, i_val}, set DDRAM address.
  - sel 001 -> 0x02, return home.
  - sel 010 and sel 011 are invalid: the request is ignored and no state change occurs.
- Request decode, character mode (i_data=1; i_sel[2] ignored):
  - sel[1:0] 00 -> hex digit: i_val 0-9 -> 0x30+i_val; i_val 10-15 -> 0x37+i_val ('A'-'F').
  - sel[1:0] 01 -> i_val[0] ? 0x20 (' ') : 0x3A (':').
  - sel[1:0] 11 -> i_val[0] ? 0x50 ('P') : 0x41 ('A').
  - sel[1:0] 10 -> 0x4D ('M').
- FSM states: IDLE, SETUP, PULSE, HOLD. An 8-bit down-counter handles phase timing.
  - IDLE: on a valid request, latch o_lcd_rs <= i_data and o_lcd_db <= decoded byte, load the counter with SETUP_CYC-1, set busy, go to SETUP.
  - SETUP: at count 0, set E high, load PULSE_CYC-1, go to PULSE.
  - PULSE: at count 0, set E low, load HOLD_CYC-1, go to HOLD.
  - HOLD: at count 0, clear busy and go to IDLE. RS and DB keep their last values in IDLE.
- Inputs are sampled only on the request edge; later changes have no effect.
- A request edge in any non-IDLE state, including the final HOLD cycle, is dropped and sets o_overrun.
- Reset mid-transaction aborts immediately: all outputs return to reset values on that edge.

## Timing
- Reset values: o_lcd_rs=0, o_lcd_rw=0, o_lcd_e=0, o_lcd_db=0x00, o_busy=0, o_overrun=0, state=IDLE, trig_d=0.
- Request edge sampled at edge N:
  - RS/DB and busy are valid after edge N.
  - E rises after edge N+SETUP_CYC.
  - E falls after edge N+SETUP_CYC+PULSE_CYC.
  - busy falls after edge N+SETUP_CYC+PULSE_CYC+HOLD_CYC.
- Busy duration is exactly SETUP_CYC+PULSE_CYC+HOLD_CYC cycles. With defaults this is 3 cycles, well under the sequencer's 35-cycle request spacing.
- The earliest next accepted request is the cycle after busy falls.
- A held-high trigger produces exactly one transaction. Re-triggering requires a low cycle first.
- o_overrun is cleared only by reset.

## Test plan
- Reset released with i_e_trigger=1, i_data=0, i_sel=100 -> one transaction: DB=0x38, RS=0; E high exactly one cycle, on the second cycle after the edge. No second transaction while the trigger stays high.
- Character sweep with i_data=1, sel 00, i_val 0..15 -> DB 0x30..0x39, then 0x41..0x46. Also cover sel 01 val 0/1 -> 0x3A/0x20; sel 11 val 0/1 -> 0x41/0x50; sel 10 -> 0x4D.
- Command with sel 000, i_val=4 -> DB=0x84, RS=0. Command with sel 010 -> no E pulse, busy stays 0.
- SETUP_CYC=3, PULSE_CYC=5, HOLD_CYC=2 -> E rises 3 cycles after the edge, stays high 5 cycles; busy lasts 10 cycles total.
- Second trigger edge during PULSE -> ignored, single E pulse, o_overrun=1 and it remains set through subsequent good transactions.
- i_reset asserted while E is high -> E=0, DB=0x00, busy=0 after that edge. A post-reset request completes normally.

Source files
------------

// File: rtl/st7066u_bus_driver.sv
`default_nettype none
// ============================================================================
// Module   : st7066u_bus_driver
// Purpose  : Expands compact sequencer requests into ST7066U command/ASCII
//            bytes and drives RS/RW/E/DB with setup, pulse and hold timing.
// Revision : 1.0 - initial release
// ============================================================================
module st7066u_bus_driver #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_e_trigger,
    input  logic       i_data,
    input  logic [2:0] i_sel,
    input  logic [3:0] i_val,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_db,
    output logic       o_busy,
    output logic       o_overrun
);

    localparam logic [7:0] c_setup_load = 8'(SETUP_CYC - 1);
    localparam logic [7:0] c_pulse_load = 8'(PULSE_CYC - 1);
    localparam logic [7:0] c_hold_load  = 8'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_db, w_db_nxt;
    logic       r_rs, w_rs_nxt;
    logic       r_e, w_e_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_overrun, w_overrun_nxt;
    logic       r_trig_d;
    logic       w_req;
    logic       w_valid;
    logic [7:0] w_byte;

    assign w_req = i_e_trigger & ~r_trig_d;

    // Request decode: selector/value pair to command or ASCII byte.
    always_comb begin
        w_valid = 1'b1;
        w_byte  = 8'h00;
        if (!i_data) begin
            case (i_sel)
                3'b100:  w_byte = 8'h38;
                3'b101:  w_byte = 8'h0C;
                3'b110:  w_byte = 8'h01;
                3'b111:  w_byte = 8'h06;
                3'b000:  w_byte = {4'h8, i_val};
                3'b001:  w_byte = 8'h02;
                default: w_valid = 1'b0;
            endcase
        end else begin
            case (i_sel[1:0])
                2'b00:   w_byte = (i_val < 4'd10) ? (8'h30 + {4'h0, i_val})
                                                  : (8'h37 + {4'h0, i_val});
                2'b01:   w_byte = i_val[0] ? 8'h20 : 8'h3A;
                2'b11:   w_byte = i_val[0] ? 8'h50 : 8'h41;
                default: w_byte = 8'h4D;
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_db_nxt      = r_db;
        w_rs_nxt      = r_rs;
        w_e_nxt       = r_e;
        w_busy_nxt    = r_busy;
        w_overrun_nxt = r_overrun | (w_req & (r_state != ST_IDLE));
        case (r_state)
            ST_IDLE: begin
                if (w_req && w_valid) begin
                    w_rs_nxt    = i_data;
                    w_db_nxt    = w_byte;
                    w_cnt_nxt   = c_setup_load;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == 8'd0) begin
                    w_e_nxt     = 1'b1;
                    w_cnt_nxt   = c_pulse_load;
                    w_state_nxt = ST_PULSE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_PULSE: begin
                if (r_cnt == 8'd0) begin
                    w_e_nxt     = 1'b0;
                    w_cnt_nxt   = c_hold_load;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 8'd0) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_db      <= 8'h00;
            r_rs      <= 1'b0;
            r_e       <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_trig_d  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_db      <= w_db_nxt;
            r_rs      <= w_rs_nxt;
            r_e       <= w_e_nxt;
            r_busy    <= w_busy_nxt;
            r_overrun <= w_overrun_nxt;
            r_trig_d  <= i_e_trigger;
        end
    end

    assign o_lcd_rs  = r_rs;
    assign o_lcd_rw  = 1'b0;
    assign o_lcd_e   = r_e;
    assign o_lcd_db  = r_db;
    assign o_busy    = r_busy;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_st7066u_bus_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_st7066u_bus_driver
// Purpose  : Bench for st7066u_bus_driver with default and stretched timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_st7066u_bus_driver;

    logic       clk;
    logic       rst;
    logic       trig;
    logic       data;
    logic [2:0] sel;
    logic [3:0] val;

    logic       a_rs, a_rw, a_e, a_busy, a_ovr;
    logic [7:0] a_db;
    logic       b_rs, b_rw, b_e, b_busy, b_ovr;
    logic [7:0] b_db;

    logic [12:0] obs_a, obs_b;
    assign obs_a = {a_rs, a_rw, a_e, a_db, a_busy, a_ovr};
    assign obs_b = {b_rs, b_rw, b_e, b_db, b_busy, b_ovr};

    int checks = 0;
    int errors = 0;

    st7066u_bus_driver dut_a (
        .i_clk(clk), .i_reset(rst), .i_e_trigger(trig), .i_data(data),
        .i_sel(sel), .i_val(val), .o_lcd_rs(a_rs), .o_lcd_rw(a_rw),
        .o_lcd_e(a_e), .o_lcd_db(a_db), .o_busy(a_busy), .o_overrun(a_ovr)
    );

    st7066u_bus_driver #(.SETUP_CYC(3), .PULSE_CYC(5), .HOLD_CYC(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_e_trigger(trig), .i_data(data),
        .i_sel(sel), .i_val(val), .o_lcd_rs(b_rs), .o_lcd_rw(b_rw),
        .o_lcd_e(b_e), .o_lcd_db(b_db), .o_busy(b_busy), .o_overrun(b_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each instance tracks the age of its current
    // transaction; busy/E windows follow directly from the phase lengths.
    int   ts[2] = '{1, 3};
    int   tp[2] = '{1, 5};
    int   th[2] = '{1, 2};
    logic       m_trig_d;
    logic       m_act[2];
    int         m_age[2];
    logic       m_rs[2];
    logic [7:0] m_db[2];
    logic       m_ovr[2];
    string      hex_digits = "0123456789ABCDEF";

    task automatic ref_decode(input logic d, input logic [2:0] s, input logic [3:0] v,
                              output logic ok, output logic [7:0] b);
        logic [7:0] cmd_tab [8];
        cmd_tab = '{8'h80, 8'h02, 8'h00, 8'h00, 8'h38, 8'h0C, 8'h01, 8'h06};
        ok = 1'b1;
        b  = 8'h00;
        if (!d) begin
            ok = !(s == 3'd2 || s == 3'd3);
            b  = cmd_tab[s] + ((s == 3'd0) ? {4'h0, v} : 8'h00);
        end else begin
            case (s[1:0])
                2'd0: b = hex_digits[v];
                2'd1: b = v[0] ? " " : ":";
                2'd3: b = v[0] ? "P" : "A";
                default: b = "M";
            endcase
        end
    endtask

    always @(posedge clk) begin : model
        logic       req, ok, was_busy;
        logic [7:0] b;
        if (rst) begin
            m_trig_d = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0; m_age[i] = 0; m_rs[i] = 1'b0;
                m_db[i] = 8'h00; m_ovr[i] = 1'b0;
            end
        end else begin
            req = trig && !m_trig_d;
            ref_decode(data, sel, val, ok, b);
            for (int i = 0; i < 2; i++) begin
                was_busy = m_act[i] && (m_age[i] < ts[i] + tp[i] + th[i]);
                if (m_act[i]) m_age[i]++;
                if (req && was_busy) m_ovr[i] = 1'b1;
                else if (req && ok) begin
                    m_act[i] = 1'b1; m_age[i] = 0; m_rs[i] = data; m_db[i] = b;
                end
            end
            m_trig_d = trig;
        end
    end

    function automatic logic [12:0] exp_vec(int i);
        logic busy, e;
        busy = m_act[i] && (m_age[i] < ts[i] + tp[i] + th[i]);
        e    = m_act[i] && (m_age[i] >= ts[i]) && (m_age[i] < ts[i] + tp[i]);
        return {m_rs[i], 1'b0, e, m_db[i], busy, m_ovr[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic d, input logic [2:0] s, input logic [3:0] v);
        trig = 1'b0;
        tick();
        trig = 1'b1; data = d; sel = s; val = v;
    endtask

    task automatic test_reset();
        int ea, eb;
        rst = 1'b1; trig = 1'b1; data = 1'b0; sel = 3'b100; val = 4'h0;
        repeat (2) tick();
        checks++; if (obs_a !== 13'h0) begin errors++; $display("FAIL reset_a got=%h want=0000", obs_a); end
        checks++; if (obs_b !== 13'h0) begin errors++; $display("FAIL reset_b got=%h want=0000", obs_b); end
        rst = 1'b0; ea = 0; eb = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            checks++; if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL reset_seq_a c=%0d got=%h want=%h", c, obs_a, exp_vec(0)); end
            checks++; if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL reset_seq_b c=%0d got=%h want=%h", c, obs_b, exp_vec(1)); end
            if (a_e) ea++;
            if (b_e) eb++;
            if (c == 1) begin
                checks++; if (a_db !== 8'h38 || a_rs !== 1'b0) begin errors++; $display("FAIL first_cmd got=%h/%b want=38/0", a_db, a_rs); end
            end
            if (c == 2) begin
                checks++; if (a_e !== 1'b1) begin errors++; $display("FAIL first_e_cycle got=%b want=1", a_e); end
            end
        end
        checks++; if (ea != 1) begin errors++; $display("FAIL held_trig_a pulses got=%0d want=1", ea); end
        checks++; if (eb != 5) begin errors++; $display("FAIL held_trig_b e_cycles got=%0d want=5", eb); end
    endtask

    task automatic test_char_sweep();
        logic [2:0] s_tab [21];
        logic [3:0] v_tab [21];
        logic [7:0] want  [21];
        for (int k = 0; k < 16; k++) begin
            s_tab[k] = 3'd0; v_tab[k] = 4'(k);
            want[k]  = (k < 10) ? 8'(8'h30 + k) : 8'(8'h41 + k - 10);
        end
        s_tab[16] = 3'd1; v_tab[16] = 4'd0; want[16] = 8'h3A;
        s_tab[17] = 3'd1; v_tab[17] = 4'd1; want[17] = 8'h20;
        s_tab[18] = 3'd3; v_tab[18] = 4'd0; want[18] = 8'h41;
        s_tab[19] = 3'd3; v_tab[19] = 4'd1; want[19] = 8'h50;
        s_tab[20] = 3'd2; v_tab[20] = 4'd9; want[20] = 8'h4D;
        for (int k = 0; k < 21; k++) begin
            issue(1'b1, {1'($urandom), s_tab[k][1:0]}, v_tab[k]);
            for (int c = 0; c < 11; c++) begin
                tick();
                checks++; if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL char_a k=%0d c=%0d got=%h want=%h", k, c, obs_a, exp_vec(0)); end
                checks++; if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL char_b k=%0d c=%0d got=%h want=%h", k, c, obs_b, exp_vec(1)); end
                if (c == 0) begin
                    data = 1'($urandom); sel = 3'($urandom); val = 4'($urandom);
                end
            end
            checks++; if (a_db !== want[k] || a_rs !== 1'b1) begin errors++; $display("FAIL char_byte k=%0d got=%h/%b want=%h/1", k, a_db, a_rs, want[k]); end
        end
    endtask

    task automatic test_cmd();
        int seen;
        issue(1'b0, 3'b000, 4'd4);
        for (int c = 0; c < 11; c++) begin
            tick();
            checks++; if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL ddram_b c=%0d got=%h want=%h", c, obs_b, exp_vec(1)); end
        end
        checks++; if (a_db !== 8'h84 || a_rs !== 1'b0) begin errors++; $display("FAIL ddram_addr got=%h/%b want=84/0", a_db, a_rs); end
        for (int k = 2; k <= 3; k++) begin
            issue(1'b0, 3'(k), 4'($urandom));
            seen = 0;
            for (int c = 0; c < 11; c++) begin
                tick();
                checks++; if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL invalid_a sel=%0d c=%0d got=%h want=%h", k, c, obs_a, exp_vec(0)); end
                if (a_e || a_busy || b_e || b_busy) seen++;
            end
            checks++; if (seen != 0) begin errors++; $display("FAIL invalid_sel sel=%0d active_cycles got=%0d want=0", k, seen); end
        end
    endtask

    task automatic test_timing();
        int rise, ecnt, bcnt, abcnt;
        issue(1'b0, 3'b101, 4'($urandom));
        rise = -1; ecnt = 0; bcnt = 0; abcnt = 0;
        for (int c = 0; c < 13; c++) begin
            tick();
            checks++; if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL timing_b c=%0d got=%h want=%h", c, obs_b, exp_vec(1)); end
            if (b_e && rise < 0) rise = c;
            if (b_e) ecnt++;
            if (b_busy) bcnt++;
            if (a_busy) abcnt++;
        end
        checks++; if (rise != 3) begin errors++; $display("FAIL e_rise got=%0d want=3", rise); end
        checks++; if (ecnt != 5) begin errors++; $display("FAIL e_width got=%0d want=5", ecnt); end
        checks++; if (bcnt != 10) begin errors++; $display("FAIL busy_len_b got=%0d want=10", bcnt); end
        checks++; if (abcnt != 3) begin errors++; $display("FAIL busy_len_a got=%0d want=3", abcnt); end
    endtask

    task automatic test_overrun();
        int ecnt;
        issue(1'b1, 3'b000, 4'd5);
        ecnt = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 4) trig = 1'b0;
            if (c == 5) trig = 1'b1;
            tick();
            checks++; if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL ovr_a c=%0d got=%h want=%h", c, obs_a, exp_vec(0)); end
            checks++; if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL ovr_b c=%0d got=%h want=%h", c, obs_b, exp_vec(1)); end
            if (b_e) ecnt++;
        end
        checks++; if (ecnt != 5) begin errors++; $display("FAIL ovr_single_pulse got=%0d want=5", ecnt); end
        checks++; if (b_ovr !== 1'b1 || a_ovr !== 1'b0) begin errors++; $display("FAIL ovr_flags got=%b/%b want=1/0", b_ovr, a_ovr); end
        issue(1'b0, 3'b111, 4'd0);
        for (int c = 0; c < 11; c++) tick();
        checks++; if (b_ovr !== 1'b1 || b_db !== 8'h06) begin errors++; $display("FAIL ovr_sticky got=%b/%h want=1/06", b_ovr, b_db); end
    endtask

    task automatic test_reset_mid();
        int ecnt;
        issue(1'b0, 3'b110, 4'd0);
        for (int c = 0; c < 4; c++) tick();
        checks++; if (b_e !== 1'b1) begin errors++; $display("FAIL mid_pre_e got=%b want=1", b_e); end
        rst = 1'b1; trig = 1'b0;
        tick();
        checks++; if (obs_b !== 13'h0) begin errors++; $display("FAIL mid_reset_b got=%h want=0000", obs_b); end
        checks++; if (obs_a !== 13'h0) begin errors++; $display("FAIL mid_reset_a got=%h want=0000", obs_a); end
        rst = 1'b0;
        tick();
        issue(1'b1, 3'b000, 4'd9);
        ecnt = 0;
        for (int c = 0; c < 11; c++) begin
            tick();
            checks++; if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL post_reset_b c=%0d got=%h want=%h", c, obs_b, exp_vec(1)); end
            if (b_e) ecnt++;
        end
        checks++; if (a_db !== 8'h39 || a_rs !== 1'b1 || ecnt != 5) begin errors++; $display("FAIL post_reset_txn got=%h/%b/%0d want=39/1/5", a_db, a_rs, ecnt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0) trig = ~trig;
            data = 1'($urandom); sel = 3'($urandom); val = 4'($urandom);
            rst  = ($urandom_range(0, 299) == 0);
            tick();
            checks++; if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL random_a c=%0d got=%h want=%h", c, obs_a, exp_vec(0)); end
            checks++; if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL random_b c=%0d got=%h want=%h", c, obs_b, exp_vec(1)); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_char_sweep();
        test_cmd();
        test_timing();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
